vc_arb2_buf_sd: RTL and testbench

- Two-requester, same-domain arbitration and buffering stage that sits directly upstream of the 2-input same-domain mux path.
- Picks one of two val/rdy message streams with round-robin priority and forms the mux select internally.
- Captures the winning message in a one-entry output register, so the downstream consumer sees a registered val/rdy stream.
- All message data carries the label {Domain domain}. All control (val/rdy/sel/priority) is {L}, so arbitration never depends on secret data.

---
 rtl/vc_arb2_buf_sd.sv | 105 ++++++++++
 tb/tb_vc_arb2_buf_sd.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vc_arb2_buf_sd.sv
// vc_arb2_buf_sd: two-requester round-robin arbiter with a one-entry output buffer.
// It selects one of two val/rdy message streams and registers the winner, so the
// consumer sees a registered val/rdy stream. Throughput is one message per cycle.
// All control (val/rdy/sel/prio) is derived from low-security signals only. Message
// data carries the label given by 'domain'.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   domain             security domain of all message data this cycle
//   in0_val/rdy/msg    requester 0 stream (in0_rdy is combinational)
//   in1_val/rdy/msg    requester 1 stream (in1_rdy is combinational)
//   out_val/rdy/msg    buffered output stream (out_val/out_msg registered)
//   out_sel            source of the buffered message (0 = in0, 1 = in1)
//
// Optional build macro VC_ARB2_BUF_SD_DOMAIN_SCRUB_EN: when domain changes, the stage
// blocks input for one cycle and clears the buffer and the priority. Without the
// macro, domain must stay stable while out_val is high.

module vc_arb2_buf_sd #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               domain,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_sel
);

  logic               out_val_reg;
  logic [p_nbits-1:0] out_msg_reg;
  logic               out_sel_reg;
  logic               prio;

  logic               scrub;
  logic               can_accept;
  logic               any_val;
  logic               grant;
  logic               xfer;
  logic [p_nbits-1:0] sel_msg;

`ifdef VC_ARB2_BUF_SD_DOMAIN_SCRUB_EN
  logic prev_domain;

  // Track the previous cycle's domain so that a label change can be detected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_domain <= 1'b0;
    else        prev_domain <= domain;
  end

  assign scrub = (domain != prev_domain);
`else
  assign scrub = 1'b0;

  // A buffered message must never be relabelled by a domain change.
  domain_stable_while_valid: assert property (
    @(posedge clk) disable iff (!reset) out_val_reg |-> $stable(domain)
  );
`endif

  // Grant and handshakes. Reset is included, so nothing is accepted while reset is held.
  always_comb begin
    can_accept = reset & (~out_val_reg | out_rdy) & ~scrub;
    any_val    = in0_val | in1_val;
    grant      = (in0_val & in1_val) ? prio : in1_val;
    in0_rdy    = can_accept & any_val & ~grant;
    in1_rdy    = can_accept & any_val & grant;
    xfer       = in0_rdy | in1_rdy;
    sel_msg    = grant ? in1_msg : in0_msg;
  end

  // Output buffer and round-robin priority. Priority flips only on a real transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val_reg <= 1'b0;
      out_msg_reg <= '0;
      out_sel_reg <= 1'b0;
      prio        <= 1'b0;
    end else if (scrub) begin
      out_val_reg <= 1'b0;
      out_msg_reg <= '0;
      out_sel_reg <= 1'b0;
      prio        <= 1'b0;
    end else if (xfer) begin
      out_val_reg <= 1'b1;
      out_msg_reg <= sel_msg;
      out_sel_reg <= grant;
      prio        <= ~grant;
    end else if (out_rdy) begin
      out_val_reg <= 1'b0;
    end
  end

  assign out_val = out_val_reg;
  assign out_msg = out_msg_reg;
  assign out_sel = out_sel_reg;

endmodule

// File: tb/tb_vc_arb2_buf_sd.sv
// Bench for vc_arb2_buf_sd: a table of per-cycle vectors plus a message scoreboard,
// then hand-written sequences for asynchronous reset and the optional domain scrub.
module tb_vc_arb2_buf_sd;

  logic        clk;
  logic        reset;
  logic        domain;
  logic        in0_val, in0_rdy;
  logic [31:0] in0_msg;
  logic        in1_val, in1_rdy;
  logic [31:0] in1_msg;
  logic        out_val, out_rdy;
  logic [31:0] out_msg;
  logic        out_sel;

  int n_checks = 0;
  int n_fail   = 0;

  vc_arb2_buf_sd #(.p_nbits(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .domain  (domain),
    .in0_val (in0_val),
    .in0_rdy (in0_rdy),
    .in0_msg (in0_msg),
    .in1_val (in1_val),
    .in1_rdy (in1_rdy),
    .in1_msg (in1_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .out_sel (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] m0;
    logic [31:0] m1;
    logic        ordy;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_oval;
  } vec_t;

  typedef struct {
    logic [31:0] msg;
    logic        sel;
  } exp_t;

  localparam int unsigned NVEC = 17;
  vec_t vecs [NVEC];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] m0,
                       input logic [31:0] m1, input logic ordy);
    in0_val = v0;
    in1_val = v1;
    in0_msg = m0;
    in1_msg = m1;
    out_rdy = ordy;
  endtask

  initial begin
    // Cycle-by-cycle sequence. Columns: v0, v1, m0, m1, out_rdy, exp in0_rdy, exp in1_rdy, exp out_val.
    vecs[0]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b1, 1'b0, 1'b0}; // first grant to in0
    vecs[1]  = '{1'b1, 1'b0, 32'hA5A5_0001, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1}; // single requester
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,         32'h33, 1'b1, 1'b0, 1'b1, 1'b0}; // in1 alone, prio->0
    vecs[4]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b1, 1'b0, 1'b1}; // round robin x6
    vecs[5]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h11,        32'h22, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h0,         32'h44, 1'b0, 1'b0, 1'b0, 1'b1}; // stall x4
    vecs[11] = '{1'b0, 1'b1, 32'h0,         32'h44, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h0,         32'h44, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h0,         32'h44, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 32'h0,         32'h44, 1'b1, 1'b0, 1'b1, 1'b1}; // release: same-cycle accept
    vecs[15] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         32'h0,  1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held with both requesters valid and the consumer ready.
    reset  = 1'b0;
    domain = 1'b0;
    drive(1'b1, 1'b1, 32'h11, 32'h22, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_msg", out_msg, 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in0_rdy", 32'(in0_rdy), 32'd0);
    check("rst_in1_rdy", 32'(in1_rdy), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    reset = 1'b1;

    // Table-driven run, with the scoreboard tracking buffered messages.
    for (int i = 0; i < int'(NVEC); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].v0, vecs[i].v1, vecs[i].m0, vecs[i].m1, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("v%0d_in0_rdy", i), 32'(in0_rdy), 32'(vecs[i].e_rdy0));
      check($sformatf("v%0d_in1_rdy", i), 32'(in1_rdy), 32'(vecs[i].e_rdy1));
      check($sformatf("v%0d_out_val", i), 32'(out_val), 32'(vecs[i].e_oval));
      if (vecs[i].e_oval) begin
        if (sb.size() == 0) begin
          check($sformatf("v%0d_sb_nonempty", i), 32'd0, 32'd1);
        end else begin
          check($sformatf("v%0d_out_msg", i), out_msg, sb[0].msg);
          check($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(sb[0].sel));
          if (vecs[i].ordy) void'(sb.pop_front());
        end
      end
      if (vecs[i].e_rdy0) sb.push_back('{vecs[i].m0, 1'b0});
      if (vecs[i].e_rdy1) sb.push_back('{vecs[i].m1, 1'b1});
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while a message is buffered: prio is 1 before the reset.
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h55, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("ar_pre_out_val", 32'(out_val), 32'd1);
    check("ar_pre_out_msg", out_msg, 32'h55);
    #1;
    reset = 1'b0;
    #1;
    check("ar_out_val_async", 32'(out_val), 32'd0);
    check("ar_out_msg_async", out_msg, 32'd0);
    drive(1'b1, 1'b1, 32'h66, 32'h77, 1'b1);
    #1;
    check("ar_in0_rdy_in_reset", 32'(in0_rdy), 32'd0);
    check("ar_in1_rdy_in_reset", 32'(in1_rdy), 32'd0);
    #3;
    reset = 1'b1;
    #1;
    check("ar_in0_rdy_prio0", 32'(in0_rdy), 32'd1);
    check("ar_in1_rdy_prio0", 32'(in1_rdy), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("ar_post_out_msg", out_msg, 32'h66);
    check("ar_post_out_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #1;
    check("ar_drained", 32'(out_val), 32'd0);

`ifdef VC_ARB2_BUF_SD_DOMAIN_SCRUB_EN
    // Domain change while a message is buffered: input is blocked, then the buffer is cleared.
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("sc_out_val", 32'(out_val), 32'd1);
    check("sc_out_msg", out_msg, 32'hDEAD_BEEF);
    domain = 1'b1;
    drive(1'b1, 1'b1, 32'h1, 32'h2, 1'b1);
    #1;
    check("sc_in0_rdy_blocked", 32'(in0_rdy), 32'd0);
    check("sc_in1_rdy_blocked", 32'(in1_rdy), 32'd0);
    @(posedge clk);
    #1;
    check("sc_out_val_cleared", 32'(out_val), 32'd0);
    check("sc_out_msg_cleared", out_msg, 32'd0);
    check("sc_in0_rdy_resume", 32'(in0_rdy), 32'd1);
    check("sc_in1_rdy_resume", 32'(in1_rdy), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("sc_new_msg", out_msg, 32'h1);
    @(posedge clk);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
